// File: rtl/valid_flop_pipe_pkg.sv
// Shared handshake definitions used by the register slices and FIFOs.
package valid_flop_pipe_pkg;

    localparam int MAX_PIPE_DEPTH = 8;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(5) = 3.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/valid_flop_pipe_stage.sv
// One forward register stage: a valid/data flop pair plus its term of the ready chain.
module valid_flop_stage
    import valid_flop_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ready_next,
    input  logic             in_valid,
    input  logic [0:WIDTH-1] in_data,
    output logic             valid,
    output logic [0:WIDTH-1] data,
    output logic             ready
);

    logic             valid_reg;
    logic [0:WIDTH-1] data_reg;

    // An empty stage always accepts, which is what collapses bubbles.
    always_comb begin
        ready = ready_next | ~valid_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (ready) begin
            valid_reg <= in_valid;
            if (in_valid) begin
                data_reg <= in_data;
            end
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;

endmodule

// File: rtl/valid_flop_pipe.sv
// Forward register slice: DEPTH bubble-collapsing valid/data stages with occupancy tracking.
module valid_flop_pipe
    import valid_flop_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW = clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             VALID_UP,
    output logic             READY_UP,
    input  logic [0:WIDTH-1] DATA_UP,
    output logic             VALID_DOWN,
    input  logic             READY_DOWN,
    output logic [0:WIDTH-1] DATA_DOWN,
    output logic [CW-1:0]    COUNT,
    output logic             EMPTY
);

    if (DEPTH < 1 || DEPTH > MAX_PIPE_DEPTH) begin : g_bad_depth
        $error("valid_flop_pipe: DEPTH must be within 1..%0d", MAX_PIPE_DEPTH);
    end

    logic [DEPTH-1:0] v;
    logic [0:WIDTH-1] d [DEPTH];
    logic [DEPTH:0]   r;
    logic             in_fire;
    logic             out_fire;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             empty_reg;

    assign r[DEPTH] = READY_DOWN;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic             stage_in_valid;
        logic [0:WIDTH-1] stage_in_data;

        if (gi == 0) begin : g_head
            assign stage_in_valid = VALID_UP;
            assign stage_in_data  = DATA_UP;
        end else begin : g_body
            assign stage_in_valid = v[gi-1];
            assign stage_in_data  = d[gi-1];
        end

        valid_flop_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk        (CLK),
            .reset      (RESET),
            .ready_next (r[gi+1]),
            .in_valid   (stage_in_valid),
            .in_data    (stage_in_data),
            .valid      (v[gi]),
            .data       (d[gi]),
            .ready      (r[gi])
        );
    end

    // Ready is forced high while RESET is held so upstream sees a clean start.
    assign READY_UP   = r[0] | RESET;
    assign VALID_DOWN = v[DEPTH-1];
    assign DATA_DOWN  = d[DEPTH-1];

    assign in_fire    = VALID_UP & r[0];
    assign out_fire   = v[DEPTH-1] & READY_DOWN;

    always_comb begin
        count_next = count_reg + CW'(in_fire) - CW'(out_fire);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_reg <= '0;
            empty_reg <= 1'b1;
        end else begin
            count_reg <= count_next;
            empty_reg <= (count_next == '0);
        end
    end

    assign COUNT = count_reg;
    assign EMPTY = empty_reg;

endmodule

// File: tb/tb_valid_flop_pipe.sv
// Directed and randomized checks of valid_flop_pipe at several depths sharing one stimulus bus.
module tb_valid_flop_pipe;

    logic        clk;
    logic        rst;
    logic        valid_up;
    logic [0:31] data_up;
    logic        ready_down;

    logic        ru1, vd1, em1;
    logic [0:31] dd1;
    logic [0:0]  cnt1;
    logic        ru2, vd2, em2;
    logic [0:31] dd2;
    logic [1:0]  cnt2;
    logic        ru3, vd3, em3;
    logic [0:31] dd3;
    logic [1:0]  cnt3;
    logic        ru4, vd4, em4;
    logic [0:31] dd4;
    logic [2:0]  cnt4;

    int n_vec  = 0;
    int n_fail = 0;

    valid_flop_pipe #(.WIDTH(32), .DEPTH(1)) u1 (
        .CLK(clk), .RESET(rst), .VALID_UP(valid_up), .READY_UP(ru1), .DATA_UP(data_up),
        .VALID_DOWN(vd1), .READY_DOWN(ready_down), .DATA_DOWN(dd1), .COUNT(cnt1), .EMPTY(em1));
    valid_flop_pipe #(.WIDTH(32), .DEPTH(2)) u2 (
        .CLK(clk), .RESET(rst), .VALID_UP(valid_up), .READY_UP(ru2), .DATA_UP(data_up),
        .VALID_DOWN(vd2), .READY_DOWN(ready_down), .DATA_DOWN(dd2), .COUNT(cnt2), .EMPTY(em2));
    valid_flop_pipe #(.WIDTH(32), .DEPTH(3)) u3 (
        .CLK(clk), .RESET(rst), .VALID_UP(valid_up), .READY_UP(ru3), .DATA_UP(data_up),
        .VALID_DOWN(vd3), .READY_DOWN(ready_down), .DATA_DOWN(dd3), .COUNT(cnt3), .EMPTY(em3));
    valid_flop_pipe #(.WIDTH(32), .DEPTH(4)) u4 (
        .CLK(clk), .RESET(rst), .VALID_UP(valid_up), .READY_UP(ru4), .DATA_UP(data_up),
        .VALID_DOWN(vd4), .READY_DOWN(ready_down), .DATA_DOWN(dd4), .COUNT(cnt4), .EMPTY(em4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 more unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid_up = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] q1[$];
    logic [31:0] q4[$];
    logic        stall1, stall4;
    logic [31:0] hold1, hold4;

    initial begin
        rst = 1'b1;
        valid_up = 1'b0;
        data_up = '0;
        ready_down = 1'b0;

        // Reset / idle, DEPTH=2
        tick();
        #1;
        chk("rst_cycle_ready", 32'(ru2), 32'd1);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_valid_down", 32'(vd2), 32'd0);
        chk("rst_data_down", dd2, 32'h0);
        chk("rst_count", 32'(cnt2), 32'd0);
        chk("rst_empty", 32'(em2), 32'd1);
        chk("rst_ready_up", 32'(ru2), 32'd1);

        // Streaming, DEPTH=2: beat i appears after edge i+2
        ready_down = 1'b1;
        for (int i = 0; i < 8; i++) begin
            valid_up = 1'b1;
            data_up = 32'h11 + 32'(i);
            #1;
            chk("stream_ready_up", 32'(ru2), 32'd1);
            tick();
            chk("stream_count", 32'(cnt2), (i == 0) ? 32'd1 : 32'd2);
            if (i >= 1) begin
                chk("stream_valid", 32'(vd2), 32'd1);
                chk("stream_data", dd2, 32'h11 + 32'(i - 1));
            end
        end
        valid_up = 1'b0;
        tick();
        chk("stream_last_data", dd2, 32'h18);
        chk("stream_last_valid", 32'(vd2), 32'd1);
        tick();
        chk("stream_drained_valid", 32'(vd2), 32'd0);
        chk("stream_drained_count", 32'(cnt2), 32'd0);
        chk("stream_drained_empty", 32'(em2), 32'd1);
        chk("stream_drained_hold", dd2, 32'h18);

        // Full pass-through, DEPTH=2
        do_reset();
        ready_down = 1'b0;
        valid_up = 1'b1;
        data_up = 32'h21;
        tick();
        data_up = 32'h22;
        tick();
        chk("full_count", 32'(cnt2), 32'd2);
        chk("full_data", dd2, 32'h21);
        data_up = 32'h23;
        #1;
        chk("full_stalled_ready", 32'(ru2), 32'd0);
        ready_down = 1'b1;
        #1;
        chk("full_passthru_ready", 32'(ru2), 32'd1);
        tick();
        chk("passthru_count", 32'(cnt2), 32'd2);
        chk("passthru_data", dd2, 32'h22);
        chk("passthru_empty", 32'(em2), 32'd0);

        // Backpressure fill, DEPTH=3
        do_reset();
        ready_down = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_up = 1'b1;
            data_up = 32'hA0 + 32'(i);
            #1;
            chk("bp_ready_up", 32'(ru3), 32'd1);
            tick();
        end
        data_up = 32'hA3;
        #1;
        chk("bp_full_ready", 32'(ru3), 32'd0);
        chk("bp_full_count", 32'(cnt3), 32'd3);
        chk("bp_full_data", dd3, 32'hA0);
        chk("bp_full_valid", 32'(vd3), 32'd1);
        tick();
        chk("bp_stall_data", dd3, 32'hA0);
        chk("bp_stall_count", 32'(cnt3), 32'd3);
        ready_down = 1'b1;
        #1;
        chk("bp_release_ready", 32'(ru3), 32'd1);
        tick();
        valid_up = 1'b0;
        chk("bp_out1", dd3, 32'hA1);
        tick();
        chk("bp_out2", dd3, 32'hA2);
        tick();
        chk("bp_out3", dd3, 32'hA3);
        chk("bp_out3_valid", 32'(vd3), 32'd1);
        tick();
        chk("bp_done_valid", 32'(vd3), 32'd0);
        chk("bp_done_empty", 32'(em3), 32'd1);

        // Mid-operation reset, DEPTH=4
        do_reset();
        ready_down = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_up = 1'b1;
            data_up = 32'hB0 + 32'(i);
            tick();
        end
        chk("mid_count", 32'(cnt4), 32'd3);
        valid_up = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(ru4), 32'd1);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_valid_down", 32'(vd4), 32'd0);
        chk("mid_count0", 32'(cnt4), 32'd0);
        chk("mid_empty", 32'(em4), 32'd1);
        chk("mid_ready_after", 32'(ru4), 32'd1);
        ready_down = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mid_no_ghost", 32'(vd4), 32'd0);
        end

        // Random stall, DEPTH=1 and DEPTH=4 with per-instance scoreboards
        do_reset();
        for (int c = 0; c < 3010; c++) begin
            valid_up = (c < 3000) ? ($urandom_range(0, 3) != 0) : 1'b0;
            data_up = $urandom;
            ready_down = (c < 3000) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (vd1 && ready_down) begin
                if (q1.size() == 0) chk("rnd1_spurious", 32'(vd1), 32'd0);
                else chk("rnd1_order", dd1, q1.pop_front());
            end
            if (vd4 && ready_down) begin
                if (q4.size() == 0) chk("rnd4_spurious", 32'(vd4), 32'd0);
                else chk("rnd4_order", dd4, q4.pop_front());
            end
            if (valid_up && ru1) q1.push_back(data_up);
            if (valid_up && ru4) q4.push_back(data_up);
            stall1 = vd1 && !ready_down;
            stall4 = vd4 && !ready_down;
            hold1 = dd1;
            hold4 = dd4;
            tick();
            chk("rnd1_count", 32'(cnt1), 32'(q1.size()));
            chk("rnd4_count", 32'(cnt4), 32'(q4.size()));
            if (stall1) chk("rnd1_hold", dd1, hold1);
            if (stall4) chk("rnd4_hold", dd4, hold4);
        end
        chk("rnd1_leftover", 32'(q1.size()), 32'd0);
        chk("rnd4_leftover", 32'(q4.size()), 32'd0);
        chk("rnd4_final_empty", 32'(em4), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
